// File: rtl/sht10_pkg.sv
// Shared types and constants for the SHT10 measurement scheduler.
// State encoding, channel select codes, result field widths.
package sht10_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_T,
    WAIT_T,
    START_RH,
    WAIT_RH,
    RECOVER,
    HOLD,
    FAULT
  } state_t;

  localparam logic SEL_TEMP = 1'b0;
  localparam logic SEL_RH   = 1'b1;

  localparam int TEMP_W = 14;
  localparam int RH_W   = 12;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sht10_meas_scheduler_if.sv
// Handshake bundle between the scheduler and the bit-level SHT10 driver.
// master = scheduler side, slave = driver side.
interface sht10_meas_scheduler_if;

  logic        meas_start;
  logic        meas_sel;
  logic        conn_reset;
  logic        meas_done;
  logic        meas_error;
  logic [15:0] meas_data;

  modport master (
    output meas_start,
    output meas_sel,
    output conn_reset,
    input  meas_done,
    input  meas_error,
    input  meas_data
  );

  modport slave (
    input  meas_start,
    input  meas_sel,
    input  conn_reset,
    output meas_done,
    output meas_error,
    output meas_data
  );

endinterface

// File: rtl/sht10_sched_timer.sv
// Loadable down-counter; expire is high for the last cycle of a load of N,
// so a state that loads N on entry and leaves on expire lasts N cycles.
module sht10_sched_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expire
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // next count: reload, or count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == 32'd1);

endmodule

// File: rtl/sht10_meas_scheduler.sv
// Sequences SHT10 temperature/RH pairs with retry, recovery and fault.
// Optional watchdog on driver completion: define SHT10_SCHED_WDOG_EN.
import sht10_pkg::*;

module sht10_meas_scheduler #(
  parameter int PERIOD_CYCLES  = 100_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int RESET_HOLD     = 16,
  parameter int MAX_RETRY      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               trig,
  sht10_meas_scheduler_if.master drv,
  output logic [TEMP_W-1:0]  temp_raw,
  output logic [RH_W-1:0]    rh_raw,
  output logic               sample_valid,
  output logic               busy,
  output logic               fault,
  output logic [7:0]         err_cnt
);

  // HOLD loses one cycle to START_T so sample_valid->meas_start = PERIOD
  localparam logic [31:0] HOLD_LOAD = 32'(PERIOD_CYCLES - 1);
  localparam logic [31:0] RST_LOAD  = 32'(RESET_HOLD);
  localparam logic [31:0] WDOG_LOAD = 32'(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic              sel_q, sel_d;
  logic              crst_q, crst_d;
  logic              sv_q, sv_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic [TEMP_W-1:0] shadow_q, shadow_d;
  logic [RH_W-1:0]   rh_q, rh_d;
  logic [7:0]        retry_q, retry_d;
  logic [7:0]        err_q, err_d;

  logic              tmr_load;
  logic [31:0]       tmr_val;
  logic              tmr_exp;
  logic              fail;
  logic              unused_cfg;

  sht10_sched_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

`ifdef SHT10_SCHED_WDOG_EN
  assign fail = drv.meas_error | (tmr_exp & ~drv.meas_done);
`else
  assign fail = drv.meas_error;
`endif

  assign unused_cfg = ^{drv.meas_data[15:14], WDOG_LOAD};

  // next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    sel_d    = sel_q;
    crst_d   = crst_q;
    sv_d     = 1'b0;
    fault_d  = fault_q;
    temp_d   = temp_q;
    shadow_d = shadow_q;
    rh_d     = rh_q;
    retry_d  = retry_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (enable || trig) state_d = START_T;
      end
      START_T, START_RH: begin
        start_d = 1'b1;
        if (state_q == START_RH) begin
          sel_d   = SEL_RH;
          state_d = WAIT_RH;
        end else begin
          sel_d   = SEL_TEMP;
          state_d = WAIT_T;
        end
`ifdef SHT10_SCHED_WDOG_EN
        tmr_load = 1'b1;
        tmr_val  = WDOG_LOAD;
`endif
      end
      WAIT_T, WAIT_RH: begin
        if (fail) begin
          err_d = sat_inc8(err_q);
          if (retry_q == RETRY_MAX) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            retry_d  = retry_q + 8'd1;
            crst_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = RST_LOAD;
            state_d  = RECOVER;
          end
        end else if (drv.meas_done) begin
          retry_d = '0;
          if (state_q == WAIT_T) begin
            shadow_d = drv.meas_data[TEMP_W-1:0];
            state_d  = START_RH;
          end else begin
            temp_d   = shadow_q;
            rh_d     = drv.meas_data[RH_W-1:0];
            sv_d     = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
            state_d  = HOLD;
          end
        end
      end
      RECOVER: begin
        if (tmr_exp) begin
          crst_d  = 1'b0;
          state_d = (sel_q == SEL_RH) ? START_RH : START_T;
        end
      end
      HOLD: begin
        if (trig) state_d = START_T;
        else if (!enable) state_d = IDLE;
        else if (tmr_exp) state_d = START_T;
      end
      FAULT: begin
        if (!enable && !trig) begin
          fault_d = 1'b0;
          retry_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d inside {IDLE, HOLD, FAULT});
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      sel_q    <= 1'b0;
      crst_q   <= 1'b0;
      sv_q     <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
      temp_q   <= '0;
      shadow_q <= '0;
      rh_q     <= '0;
      retry_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      sel_q    <= sel_d;
      crst_q   <= crst_d;
      sv_q     <= sv_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
      temp_q   <= temp_d;
      shadow_q <= shadow_d;
      rh_q     <= rh_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
    end
  end

  assign drv.meas_start = start_q;
  assign drv.meas_sel   = sel_q;
  assign drv.conn_reset = crst_q;
  assign temp_raw       = temp_q;
  assign rh_raw         = rh_q;
  assign sample_valid   = sv_q;
  assign busy           = busy_q;
  assign fault          = fault_q;
  assign err_cnt        = err_q;

endmodule

// File: doc/sht10_meas_scheduler.md
# sht10_meas_scheduler

- Sequences the SHT10 sensor driver through temperature/humidity measurement pairs, periodically or on demand.
- On driver error or watchdog timeout: pulses a connection reset, retries, and declares a fault when the retry budget is exhausted.
- Publishes coherent temperature/RH raw pairs; sits between the user/display logic and the bit-level SHT10 driver.

## Interface
- PERIOD_CYCLES, 100_000_000: idle cycles between the end of one pair and the start of the next (auto mode).
- TIMEOUT_CYCLES, 50_000_000: max cycles waiting for driver completion before it counts as failure.
- RESET_HOLD, 16: cycles conn_reset stays high per recovery.
- MAX_RETRY, 3: retries allowed per measurement before fault.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = periodic auto-scheduling.
- trig  in  1  one-cycle request for an immediate pair; honoured in IDLE or HOLD only.
- meas_start  out  1  one-cycle pulse to the driver starting a measurement.
- meas_sel  out  1  0 = temperature, 1 = RH; stable from meas_start until done/error.
- conn_reset  out  1  driver connection-reset request.
- meas_done  in  1  driver one-cycle completion pulse.
- meas_error  in  1  driver one-cycle failure pulse (NACK/CRC).
- meas_data  in  16  driver result; valid only with meas_done.
- temp_raw  out  14  last published temperature (meas_data[13:0]).
- rh_raw  out  12  last published RH (meas_data[11:0]).
- sample_valid  out  1  one-cycle pulse when temp_raw/rh_raw update.
- busy  out  1  high in any state except IDLE, HOLD, FAULT.
- fault  out  1  retry budget exhausted.
- err_cnt  out  8  saturating count of failed attempts (saturates at 255).

## Operation
- Reset values:
  - outputs: meas_start, meas_sel, conn_reset, sample_valid, busy, fault = 0; temp_raw, rh_raw, err_cnt = 0.
  - internal state: state = IDLE; retry, timers = 0.
- States:
  - IDLE: enable=1 or trig → START_T.
  - START_T: meas_start=1, meas_sel=0 → WAIT_T.
  - WAIT_T:
    - meas_done → shadow temp ← meas_data[13:0], retry=0 → START_RH.
    - meas_error or timeout → RECOVER.
  - START_RH / WAIT_RH: same as START_T / WAIT_T with meas_sel=1. On done, publish shadow temp and meas_data[11:0] together, pulse sample_valid, retry=0 → HOLD.
  - RECOVER:
    - err_cnt++ (saturating).
    - retry == MAX_RETRY → FAULT.
    - else retry++, conn_reset=1 for RESET_HOLD cycles → re-enter START of the same measurement (meas_sel unchanged).
  - HOLD:
    - counts PERIOD_CYCLES → START_T if enable=1, else IDLE.
    - trig → START_T immediately.
    - enable=0 → IDLE immediately.
  - FAULT: fault=1; leaves to IDLE only when enable=0 and trig=0; fault clears on exit.
- Boundary rules:
  - meas_done and meas_error in the same cycle: error wins, data discarded.
  - meas_done/meas_error outside WAIT_x: ignored.
  - trig while busy: dropped, not queued.
  - enable falling mid-pair: the current pair completes, then → IDLE.
  - A failed RH retry does not redo temperature; the shadow temp is kept.
  - Reset asserted mid-operation: immediate async return to reset values; the driver sees meas_start=0, conn_reset=0.

## Timing
- meas_start asserted exactly one cycle, the cycle after entering START_x.
- Timeout counter starts the cycle after meas_start and clears on leaving WAIT_x. Failure is declared when the count reaches TIMEOUT_CYCLES with no done/error.
- sample_valid and the updated temp_raw/rh_raw become visible the cycle after the meas_done that completes RH (1-cycle latency). The outputs hold until the next publish.
- conn_reset goes high the cycle after the error is sampled, for exactly RESET_HOLD cycles. The retry meas_start follows one cycle after conn_reset falls.
- HOLD duration: exactly PERIOD_CYCLES cycles from sample_valid to the next meas_start (auto mode).
- All outputs are registered.

## Configuration
- SHT10_SCHED_WDOG_EN:
  - Defined: the TIMEOUT_CYCLES watchdog is active as above.
  - Undefined: no timeout counter is built; WAIT_x leaves only on meas_done/meas_error, and TIMEOUT_CYCLES is unused.

## Structure
- Shared package sht10_pkg holds:
  - state enum (IDLE, START_T, WAIT_T, START_RH, WAIT_RH, RECOVER, HOLD, FAULT);
  - SEL_TEMP=0, SEL_RH=1;
  - field widths TEMP_W=14, RH_W=12.
- One sub-module, sht10_sched_timer: loadable down-counter with expire pulse. Shared by HOLD, RECOVER (RESET_HOLD) and the watchdog, since only one runs at a time.

## Test plan
Bench parameters: PERIOD_CYCLES=1000, TIMEOUT_CYCLES=500, RESET_HOLD=16, MAX_RETRY=2.

- Auto pair: enable=1; model answers temp 0x1A2B and RH 0x0456 → sample_valid once with temp_raw=0x1A2B, rh_raw=0x456. The next meas_start comes exactly 1000 cycles later.
- Manual trig: enable=0, trig pulse → one pair then IDLE. A second trig while busy is dropped (one sample_valid total).
- Recovery: one meas_error on RH → conn_reset high 16 cycles; RH (meas_sel=1) re-issued, temperature not repeated; err_cnt=1; publish succeeds.
- Fault: model never answers (WDOG_EN defined) → 3 timeouts of 500 cycles each, err_cnt=3, fault=1. Dropping enable → IDLE, fault=0.
- Collision: meas_done and meas_error in the same cycle in WAIT_T → treated as error; temp_raw unchanged.
- Reset mid-WAIT_RH → all outputs at reset values on the following edge; no sample_valid.
